// File: rtl/esp_at_pkg.sv
// Shared constants, parser state encoding and character helpers for the ESP AT receiver.
// The IPD parser states only exist when ESP_AT_RX_IPD_EN is defined.
package esp_at_pkg;

  localparam int LEN_W = 11;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_GT    = 8'h3E;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_SP    = 8'h20;

  // Match strings; the link digit of CONNECT/CLOSED lines is checked separately
  localparam logic [15:0] STR_OK      = "OK";
  localparam logic [39:0] STR_ERROR   = "ERROR";
  localparam logic [63:0] STR_CONNECT = ",CONNECT";
  localparam logic [55:0] STR_CLOSED  = ",CLOSED";
  localparam logic [31:0] STR_IPD     = "+IPD";

  typedef enum logic [2:0] {
    S_LINE,
    S_PROMPT,
`ifdef ESP_AT_RX_IPD_EN
    S_IPD_ID,
    S_IPD_COMMA,
    S_IPD_LEN,
    S_PAYLOAD,
`endif
    S_DISCARD
  } parse_state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_link_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h34);
  endfunction

endpackage

// File: rtl/esp_at_rx_uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle byte strobe.
// Bytes whose stop bit reads low are dropped and reported on frame_err instead.
module uart_rx #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       frame_err
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int CNT_W = $clog2(CYCLE);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

  uart_state_t      state, state_next;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_end, half_end;

  assign bit_end  = (cnt == CNT_W'(CYCLE - 1));
  assign half_end = (cnt == CNT_W'(CYCLE / 2 - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= U_IDLE;
    else     state <= state_next;
  end

  // A start needs a real falling edge, so a low line left by a bad stop bit cannot retrigger
  always_comb begin
    state_next = state;
    case (state)
      U_IDLE:  if (rx_prev && !rx_sync) state_next = U_START;
      U_START: if (half_end) state_next = rx_sync ? U_IDLE : U_DATA;
      U_DATA:  if (bit_end && bit_idx == 3'd7) state_next = U_STOP;
      U_STOP:  if (bit_end) state_next = U_IDLE;
      default: state_next = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rx_data_valid <= 1'b0;
      frame_err     <= 1'b0;
      if (state == U_IDLE || state != state_next || (state == U_DATA && bit_end))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      if (state == U_IDLE) bit_idx <= '0;
      if (state == U_DATA && bit_end) begin
        shift   <= {rx_sync, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == U_STOP && bit_end) begin
        if (rx_sync) begin
          rx_data       <= shift;
          rx_data_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/esp_at_rx.sv
// ESP AT response parser: decodes OK/ERROR/prompt/CONNECT/CLOSED lines from a UART stream.
// Define ESP_AT_RX_IPD_EN to add +IPD header parsing and the payload byte stream.
module esp_at_rx
  import esp_at_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int MAX_LINE  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  output logic             resp_ok,
  output logic             resp_error,
  output logic             prompt,
  output logic             conn_open,
  output logic             conn_close,
  output logic [2:0]       link_id,
  output logic [LEN_W-1:0] ipd_len,
  output logic [7:0]       pl_data,
  output logic             pl_valid,
  output logic             pl_last,
  output logic             rx_err
);

  localparam int LL_W  = $clog2(MAX_LINE + 1);
  localparam int IDX_W = $clog2(MAX_LINE);

  parse_state_t    state, state_next;
  logic [7:0]      rx_data;
  logic            rx_valid, frame_err;
  logic [7:0]      line_buf [MAX_LINE];
  logic [LL_W-1:0] line_len;
  logic            ok_n, error_n, prompt_n, open_n, close_n, err_n;
  logic            link_load, buf_push, buf_clear;
  logic [2:0]      link_val;

  uart_rx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE)) u_uart (
    .clk           (clk),
    .rst           (rst),
    .rx_pin        (uart_rx),
    .rx_data       (rx_data),
    .rx_data_valid (rx_valid),
    .frame_err     (frame_err)
  );

`ifdef ESP_AT_RX_IPD_EN
  logic             len_clear, len_push, ipd_load, pay_inc, pl_valid_n, pl_last_n;
  logic [11:0]      len_acc;
  logic             len_ovf;
  logic [15:0]      len_mul;
  logic [LEN_W-1:0] pay_cnt;

  assign len_mul = (16'(len_acc) * 16'd10) + {8'd0, rx_data - 8'h30};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LINE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ok_n       = 1'b0;
    error_n    = 1'b0;
    prompt_n   = 1'b0;
    open_n     = 1'b0;
    close_n    = 1'b0;
    err_n      = 1'b0;
    link_load  = 1'b0;
    link_val   = rx_data[2:0];
    buf_push   = 1'b0;
    buf_clear  = 1'b0;
`ifdef ESP_AT_RX_IPD_EN
    len_clear  = 1'b0;
    len_push   = 1'b0;
    ipd_load   = 1'b0;
    pay_inc    = 1'b0;
    pl_valid_n = 1'b0;
    pl_last_n  = 1'b0;
`endif
    if (rx_valid) begin
      case (state)
        S_LINE: begin
          if (rx_data == CH_LF) begin
            buf_clear = 1'b1;
            if (line_len == LL_W'(2) && {line_buf[0], line_buf[1]} == STR_OK)
              ok_n = 1'b1;
            else if (line_len == LL_W'(5) &&
                     {line_buf[0], line_buf[1], line_buf[2], line_buf[3], line_buf[4]} == STR_ERROR)
              error_n = 1'b1;
            else if (line_len == LL_W'(9) && is_link_digit(line_buf[0]) &&
                     {line_buf[1], line_buf[2], line_buf[3], line_buf[4], line_buf[5],
                      line_buf[6], line_buf[7], line_buf[8]} == STR_CONNECT) begin
              open_n    = 1'b1;
              link_load = 1'b1;
              link_val  = line_buf[0][2:0];
            end else if (line_len == LL_W'(8) && is_link_digit(line_buf[0]) &&
                         {line_buf[1], line_buf[2], line_buf[3], line_buf[4], line_buf[5],
                          line_buf[6], line_buf[7]} == STR_CLOSED) begin
              close_n   = 1'b1;
              link_load = 1'b1;
              link_val  = line_buf[0][2:0];
            end
          end else if (rx_data != CH_CR) begin
            if (line_len == '0 && rx_data == CH_GT)
              state_next = S_PROMPT;
`ifdef ESP_AT_RX_IPD_EN
            else if (rx_data == CH_COMMA && line_len == LL_W'(4) &&
                     {line_buf[0], line_buf[1], line_buf[2], line_buf[3]} == STR_IPD) begin
              state_next = S_IPD_ID;
              buf_clear  = 1'b1;
            end
`endif
            else if (line_len == LL_W'(MAX_LINE)) begin
              state_next = S_DISCARD;
              buf_clear  = 1'b1;
            end else
              buf_push = 1'b1;
          end
        end
        S_PROMPT: begin
          state_next = S_LINE;
          prompt_n   = (rx_data == CH_SP);
        end
`ifdef ESP_AT_RX_IPD_EN
        S_IPD_ID: begin
          if (is_link_digit(rx_data)) begin
            link_load  = 1'b1;
            state_next = S_IPD_COMMA;
          end else begin
            err_n      = 1'b1;
            state_next = S_DISCARD;
          end
        end
        S_IPD_COMMA: begin
          if (rx_data == CH_COMMA) begin
            len_clear  = 1'b1;
            state_next = S_IPD_LEN;
          end else begin
            err_n      = 1'b1;
            state_next = S_DISCARD;
          end
        end
        // An oversize length still ends its header at ':', so the next line parses normally
        S_IPD_LEN: begin
          if (is_digit(rx_data))
            len_push = 1'b1;
          else if (rx_data == CH_COLON) begin
            if (len_ovf) begin
              err_n      = 1'b1;
              state_next = S_LINE;
            end else begin
              ipd_load   = 1'b1;
              state_next = (len_acc == 12'd0) ? S_LINE : S_PAYLOAD;
            end
          end else begin
            err_n      = 1'b1;
            state_next = S_DISCARD;
          end
        end
        S_PAYLOAD: begin
          pl_valid_n = 1'b1;
          if (pay_cnt + LEN_W'(1) == ipd_len) begin
            pl_last_n  = 1'b1;
            state_next = S_LINE;
          end else
            pay_inc = 1'b1;
        end
`endif
        S_DISCARD: begin
          if (rx_data == CH_LF) begin
            state_next = S_LINE;
            buf_clear  = 1'b1;
          end
        end
        default: state_next = S_LINE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_len   <= '0;
      for (int i = 0; i < MAX_LINE; i++) line_buf[i] <= '0;
      resp_ok    <= 1'b0;
      resp_error <= 1'b0;
      prompt     <= 1'b0;
      conn_open  <= 1'b0;
      conn_close <= 1'b0;
      rx_err     <= 1'b0;
      link_id    <= '0;
    end else begin
      resp_ok    <= ok_n;
      resp_error <= error_n;
      prompt     <= prompt_n;
      conn_open  <= open_n;
      conn_close <= close_n;
      rx_err     <= err_n | frame_err;
      if (link_load) link_id <= link_val;
      if (buf_clear)
        line_len <= '0;
      else if (buf_push) begin
        line_buf[line_len[IDX_W-1:0]] <= rx_data;
        line_len                      <= line_len + LL_W'(1);
      end
    end
  end

`ifdef ESP_AT_RX_IPD_EN
  // len_ovf is sticky so a length that wraps the 12-bit accumulator is still rejected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_acc  <= '0;
      len_ovf  <= 1'b0;
      pay_cnt  <= '0;
      ipd_len  <= '0;
      pl_data  <= '0;
      pl_valid <= 1'b0;
      pl_last  <= 1'b0;
    end else begin
      pl_valid <= pl_valid_n;
      pl_last  <= pl_last_n;
      pl_data  <= pl_valid_n ? rx_data : 8'h00;
      if (len_clear) begin
        len_acc <= '0;
        len_ovf <= 1'b0;
      end else if (len_push) begin
        len_acc <= len_mul[11:0];
        if (len_mul > 16'd2047) len_ovf <= 1'b1;
      end
      if (ipd_load) begin
        ipd_len <= len_acc[LEN_W-1:0];
        pay_cnt <= '0;
      end else if (pay_inc)
        pay_cnt <= pay_cnt + LEN_W'(1);
    end
  end
`else
  assign ipd_len  = '0;
  assign pl_data  = '0;
  assign pl_valid = 1'b0;
  assign pl_last  = 1'b0;
`endif

endmodule
